// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with its own fractional-accumulator tick.
// Uses 2-of-3 majority sampling at mid-bit and delivers bytes through a valid/ack holding register.
module uart_rx_os #(
  parameter int ClkFrequency = 12000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  function automatic int bitcount(input int v);
    int n;
    n = 0;
    while (n < 32 && (v >> n) != 0) n++;
    return n;
  endfunction

  localparam int AccWidth     = bitcount(ClkFrequency / Baud) + 8;
  // Pre-scale both operands so the rounded increment never needs more than 32 bits.
  localparam int ShiftLimiter = bitcount((Baud * Oversampling) >> (31 - AccWidth));
  localparam longint IncL = ((longint'(Baud * Oversampling) << (AccWidth - ShiftLimiter))
                            + longint'(ClkFrequency >> (ShiftLimiter + 1)))
                            / longint'(ClkFrequency >> ShiftLimiter);
  localparam logic [AccWidth:0] Inc = IncL[AccWidth:0];

  localparam int H  = Oversampling / 2;
  localparam int PW = $clog2(Oversampling);
  localparam logic [PW-1:0] PLast = PW'(Oversampling - 1);
  localparam logic [PW-1:0] PS0   = PW'(H - 1);
  localparam logic [PW-1:0] PS1   = PW'(H);
  localparam logic [PW-1:0] PDec  = PW'(H + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

  logic                rx_meta_q, rx_s_q;
  logic [AccWidth:0]   acc_q, acc_d;
  state_e              state_q, state_d;
  logic [PW-1:0]       p_q, p_d, p_nx;
  logic [2:0]          bit_q, bit_d;
  logic [1:0]          smp_q, smp_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                tick, maj, deliver, frame_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      acc_q       <= '0;
      state_q     <= IDLE;
      p_q         <= '0;
      bit_q       <= '0;
      smp_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      acc_q       <= acc_d;
      state_q     <= state_d;
      p_q         <= p_d;
      bit_q       <= bit_d;
      smp_q       <= smp_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Decisions look at the position the current tick advances to, so the
  // detection tick itself is position 0 of the start bit.
  always_comb begin
    acc_d    = {1'b0, acc_q[AccWidth-1:0]} + Inc;
    tick     = acc_q[AccWidth];
    p_nx     = (p_q == PLast) ? '0 : p_q + 1'b1;
    maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
    state_d  = state_q;
    p_d      = p_q;
    bit_d    = bit_q;
    smp_d    = smp_q;
    shift_d  = shift_q;
    deliver  = 1'b0;
    frame_ev = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && !rx_s_q) begin
          state_d = START;
          p_d     = '0;
        end
      end
      START, DATA, STOP: begin
        if (tick) begin
          p_d = p_nx;
          if (p_nx == PS0) smp_d[0] = rx_s_q;
          if (p_nx == PS1) smp_d[1] = rx_s_q;
          if (p_nx == PDec) begin
            if (state_q == START && maj) begin
              state_d = IDLE;
            end else if (state_q == DATA) begin
              shift_d = {maj, shift_q[7:1]};
            end else if (state_q == STOP) begin
              state_d  = maj ? IDLE : BREAK;
              deliver  = maj;
              frame_ev = !maj;
            end
          end
          if (p_q == PLast) begin
            if (state_q == START) begin
              state_d = DATA;
              bit_d   = '0;
            end else if (state_q == DATA) begin
              if (bit_q == 3'd7) state_d = STOP;
              else               bit_d   = bit_q + 3'd1;
            end
          end
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q & ~ack;
    overrun_d   = 1'b0;
    frame_err_d = frame_ev;
    if (deliver) begin
      data_d    = shift_q;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~ack;
    end
    busy = (state_q != IDLE);
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
